xor_train_scheduler: RTL and testbench

Sequencer for the XOR training loop. It walks the four XOR samples in a fixed order and drives each one through the forward-propagation block, then the back-propagation block. Per epoch it tracks the worst-case output error and stops on convergence, on the epoch limit, or on a user stop. It sits above `forward_propagation` and the BP block and owns their enable handshakes.

---
 rtl/xor_train_scheduler.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_xor_train_scheduler.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_train_scheduler.sv
// ---------------------------------------------------------------------------
// xor_train_scheduler
//
// Sequencer for the XOR training loop. Walks the four XOR samples in a fixed
// order, drives each through the forward-propagation block and then the
// back-propagation block, and tracks the worst-case |target - y| per epoch.
// Training ends on convergence, on the epoch limit, or on a user stop.
//
// Optional feature: define TRAIN_WATCHDOG_EN to add a handshake watchdog
// that ends training with timeout=1 if FP or BP does not complete within
// TIMEOUT_CYC cycles. Without it the block waits indefinitely and timeout=0.
//
// Parameters:
//   MAX_EPOCHS   epoch limit (must be < 2**EPOCH_W)
//   EPOCH_W      width of the epoch counter
//   ERR_THRESH   convergence threshold on the per-epoch max error, 8.8
//   TIMEOUT_CYC  watchdog limit in cycles (watchdog builds only)
//
// Ports:
//   clk, rst             clock (posedge), asynchronous active-high reset
//   start, stop          begin training / request abort at next sample end
//   enable_fp, fp_valid  FP one-cycle start pulse / FP completion level
//   y                    FP output, signed 8.8
//   enable_bp, bp_done   BP one-cycle start pulse / BP completion level
//   x1, x2, target       current sample, signed 8.8
//   sample_idx           current sample index 0..3
//   epoch_count          number of completed epochs
//   epoch_err            max |target - y| of the last completed epoch
//   busy, done           running / finished (done held until next start)
//   converged, timeout   reason flags, held with done
// ---------------------------------------------------------------------------
module xor_train_scheduler #(
  parameter int                 MAX_EPOCHS  = 1000,
  parameter int                 EPOCH_W     = 16,
  parameter logic signed [15:0] ERR_THRESH  = 16'sd13,
  parameter int                 TIMEOUT_CYC = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stop,
  output logic                      enable_fp,
  input  logic                      fp_valid,
  input  logic signed [15:0]        y,
  output logic                      enable_bp,
  input  logic                      bp_done,
  output logic signed [15:0]        x1,
  output logic signed [15:0]        x2,
  output logic signed [15:0]        target,
  output logic [1:0]                sample_idx,
  output logic [EPOCH_W-1:0]        epoch_count,
  output logic [15:0]               epoch_err,
  output logic                      busy,
  output logic                      done,
  output logic                      converged,
  output logic                      timeout
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_FP_START, S_FP_WAIT, S_BP_START,
    S_BP_WAIT, S_NEXT, S_EPOCH_END, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic                fp_valid_q, bp_done_q;
  logic                stop_q, stop_d;
  logic [1:0]          idx_q, idx_d;
  logic signed [15:0]  x1_q, x1_d, x2_q, x2_d, target_q, target_d;
  logic [15:0]         max_q, max_d;
  logic [15:0]         epoch_err_q, epoch_err_d;
  logic [EPOCH_W-1:0]  epoch_count_q, epoch_count_d, epoch_inc;
  logic                enable_fp_q, enable_fp_d, enable_bp_q, enable_bp_d;
  logic                busy_q, busy_d, done_q, done_d, conv_q, conv_d;

  logic                fp_rise, bp_rise, wd_expire;
  logic                converge_hit, limit_hit, in_wait, accept_start;
  logic signed [16:0]  diff, abs_diff;
  logic [15:0]         err_sat;

  // Completion inputs are levels; only a fresh rising edge counts.
  assign fp_rise = fp_valid & ~fp_valid_q;
  assign bp_rise = bp_done & ~bp_done_q;

  // |target - y| in 17 bits cannot overflow for 16-bit operands. It is
  // clamped to the positive 16-bit signed range so it compares cleanly
  // against the signed threshold.
  assign diff     = $signed({target_q[15], target_q}) - $signed({y[15], y});
  assign abs_diff = diff[16] ? -diff : diff;
  assign err_sat  = (abs_diff > 17'sd32767) ? 16'h7FFF : abs_diff[15:0];

  assign epoch_inc    = epoch_count_q + EPOCH_W'(1);
  assign converge_hit = ($signed(max_q) <= ERR_THRESH);
  assign limit_hit    = (epoch_inc == EPOCH_W'(MAX_EPOCHS));
  assign in_wait      = (state_q == S_FP_WAIT) || (state_q == S_BP_WAIT);
  assign accept_start = ((state_q == S_IDLE) || (state_q == S_DONE)) &&
                        (state_d == S_LOAD);

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start && !stop) state_d = S_LOAD;
      S_LOAD:         state_d = S_FP_START;
      S_FP_START:     state_d = S_FP_WAIT;
      S_FP_WAIT: begin
        if (fp_rise)        state_d = S_BP_START;
        else if (wd_expire) state_d = S_DONE;
      end
      S_BP_START:     state_d = S_BP_WAIT;
      S_BP_WAIT: begin
        if (bp_rise)        state_d = S_NEXT;
        else if (wd_expire) state_d = S_DONE;
      end
      S_NEXT: begin
        if (stop_q)              state_d = S_DONE;
        else if (idx_q == 2'd3)  state_d = S_EPOCH_END;
        else                     state_d = S_LOAD;
      end
      S_EPOCH_END: state_d = (converge_hit || limit_hit) ? S_DONE : S_LOAD;
      default:     state_d = S_IDLE;
    endcase
  end

  // ------------------------------------------------------- outputs / datapath
  // Pulse and status outputs are decoded from the next state so they are
  // registered yet line up with the state they belong to.
  always_comb begin
    stop_d        = stop_q;
    idx_d         = idx_q;
    x1_d          = x1_q;
    x2_d          = x2_q;
    target_d      = target_q;
    max_d         = max_q;
    epoch_err_d   = epoch_err_q;
    epoch_count_d = epoch_count_q;
    done_d        = done_q;
    conv_d        = conv_q;
    enable_fp_d   = (state_d == S_FP_START);
    enable_bp_d   = (state_d == S_BP_START);
    busy_d        = (state_d != S_IDLE) && (state_d != S_DONE);

    if ((state_q != S_IDLE) && (state_q != S_DONE) && stop) stop_d = 1'b1;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept_start) begin
          stop_d        = 1'b0;
          idx_d         = 2'd0;
          max_d         = '0;
          epoch_count_d = '0;
          done_d        = 1'b0;
          conv_d        = 1'b0;
        end
      end
      S_LOAD: begin
        // XOR truth table: x1 = idx[1], x2 = idx[0], target = x1 ^ x2 (1.0 = 256).
        x1_d     = idx_q[1] ? 16'sd256 : 16'sd0;
        x2_d     = idx_q[0] ? 16'sd256 : 16'sd0;
        target_d = (idx_q[1] ^ idx_q[0]) ? 16'sd256 : 16'sd0;
      end
      S_FP_WAIT: begin
        if (fp_rise) begin
          if (err_sat > max_q) max_d = err_sat;
        end else if (state_d == S_DONE) begin
          done_d = 1'b1;
          conv_d = 1'b0;
        end
      end
      S_BP_WAIT: begin
        if (state_d == S_DONE) begin
          done_d = 1'b1;
          conv_d = 1'b0;
        end
      end
      S_NEXT: begin
        if (state_d == S_DONE) begin
          done_d = 1'b1;
          conv_d = 1'b0;
        end else if (state_d == S_LOAD) begin
          idx_d = idx_q + 2'd1;
        end
      end
      S_EPOCH_END: begin
        epoch_err_d   = max_q;
        max_d         = '0;
        epoch_count_d = epoch_inc;
        idx_d         = 2'd0;
        if (state_d == S_DONE) begin
          done_d = 1'b1;
          conv_d = converge_hit;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fp_valid_q    <= 1'b0;
      bp_done_q     <= 1'b0;
      stop_q        <= 1'b0;
      idx_q         <= '0;
      x1_q          <= '0;
      x2_q          <= '0;
      target_q      <= '0;
      max_q         <= '0;
      epoch_err_q   <= '0;
      epoch_count_q <= '0;
      enable_fp_q   <= 1'b0;
      enable_bp_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      conv_q        <= 1'b0;
    end else begin
      // Edge detectors track the inputs in every state so a level left high
      // from the previous sample never looks like a new completion.
      fp_valid_q    <= fp_valid;
      bp_done_q     <= bp_done;
      stop_q        <= stop_d;
      idx_q         <= idx_d;
      x1_q          <= x1_d;
      x2_q          <= x2_d;
      target_q      <= target_d;
      max_q         <= max_d;
      epoch_err_q   <= epoch_err_d;
      epoch_count_q <= epoch_count_d;
      enable_fp_q   <= enable_fp_d;
      enable_bp_q   <= enable_bp_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      conv_q        <= conv_d;
    end
  end

  // ----------------------------------------------------------------- watchdog
`ifdef TRAIN_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;

  // Counter is zero in every non-wait state, so it starts from zero on each
  // entry into FP_WAIT or BP_WAIT.
  assign wd_expire = in_wait && (wd_q == WD_W'(TIMEOUT_CYC - 1));

  always_comb begin
    wd_d      = in_wait ? (wd_q + WD_W'(1)) : '0;
    timeout_d = timeout_q;
    if (accept_start)                     timeout_d = 1'b0;
    else if (in_wait && !fp_rise && !bp_rise && wd_expire) timeout_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_wd_cfg;
  assign unused_wd_cfg = (TIMEOUT_CYC == 0) | in_wait;
  assign wd_expire     = 1'b0;
  assign timeout       = 1'b0;
`endif

  assign enable_fp   = enable_fp_q;
  assign enable_bp   = enable_bp_q;
  assign x1          = x1_q;
  assign x2          = x2_q;
  assign target      = target_q;
  assign sample_idx  = idx_q;
  assign epoch_count = epoch_count_q;
  assign epoch_err   = epoch_err_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign converged   = conv_q;

endmodule

// File: tb/tb_xor_train_scheduler.sv
// ---------------------------------------------------------------------------
// tb_xor_train_scheduler
//
// Directed bench for xor_train_scheduler (built with MAX_EPOCHS=3). Behavioural
// FP/BP models answer after 6 cycles; a table of training scenarios is run
// in a loop, followed by hand-written stop, reset, idle start+stop and
// (when TRAIN_WATCHDOG_EN is defined) watchdog sequences.
// ---------------------------------------------------------------------------
module tb_xor_train_scheduler;

  logic               clk = 1'b0;
  logic               rst, start, stop, fp_valid, bp_done;
  logic signed [15:0] y;
  logic               enable_fp, enable_bp, busy, done, converged, timeout;
  logic signed [15:0] x1, x2, target;
  logic [1:0]         sample_idx;
  logic [15:0]        epoch_count, epoch_err;

  always #5 clk = ~clk;

  xor_train_scheduler #(
    .MAX_EPOCHS (3),
    .EPOCH_W    (16),
    .ERR_THRESH (16'sd13),
    .TIMEOUT_CYC(64)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .enable_fp(enable_fp), .fp_valid(fp_valid), .y(y),
    .enable_bp(enable_bp), .bp_done(bp_done),
    .x1(x1), .x2(x2), .target(target), .sample_idx(sample_idx),
    .epoch_count(epoch_count), .epoch_err(epoch_err),
    .busy(busy), .done(done), .converged(converged), .timeout(timeout)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ------------------------------------------------------------ FP/BP models
  bit y_fixed, sticky, bp_never, chk_lat;
  int y_val;
  int fp_cnt, fp_drop, bp_cnt;
  bit exp_bp;
  int fp_pulses, bp_pulses;
  int log_idx [16];
  int log_x1  [16];
  int log_x2  [16];
  int log_tg  [16];

  always @(negedge clk) begin
    if (rst) begin
      fp_cnt = 0; fp_drop = 0; bp_cnt = 0; exp_bp = 0;
      fp_valid = 1'b0; bp_done = 1'b0;
    end else begin
      if (exp_bp) begin
        if (chk_lat) chk("bp_latency", enable_bp, 1);
        exp_bp = 0;
      end
      if (enable_fp) begin
        if (fp_pulses < 16) begin
          log_idx[fp_pulses] = sample_idx;
          log_x1[fp_pulses]  = x1;
          log_x2[fp_pulses]  = x2;
          log_tg[fp_pulses]  = target;
        end
        fp_pulses++;
        fp_cnt = 6;
        if (sticky) fp_drop = 2;
        else        fp_valid = 1'b0;
      end else begin
        if (fp_drop > 0) begin
          fp_drop--;
          if (fp_drop == 0) fp_valid = 1'b0;
        end
        if (fp_cnt > 0) begin
          fp_cnt--;
          if (fp_cnt == 0) begin
            y = y_fixed ? 16'(y_val) : 16'(int'(target) + y_val);
            fp_valid = 1'b1;
            exp_bp = 1;
          end
        end
      end
      if (enable_bp) begin
        bp_pulses++;
        bp_cnt = 6;
        bp_done = 1'b0;
      end else if (bp_cnt > 0) begin
        bp_cnt--;
        if (bp_cnt == 0 && !bp_never) bp_done = 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------ tables
  typedef struct {
    bit y_fixed; int y_val; bit sticky;
    bit exp_conv; int exp_epochs; int exp_err; int exp_pulses;
  } scen_t;

  typedef struct { int x1; int x2; int tg; } smp_t;

  scen_t tbl [5];
  smp_t  smp [4];

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("done_reached", done, 1);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_conv"}, converged, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_en_fp"}, enable_fp, 0);
    chk({tag, "_en_bp"}, enable_bp, 0);
    chk({tag, "_x"}, {x1, x2, target}, 0);
    chk({tag, "_idx"}, sample_idx, 0);
    chk({tag, "_epochs"}, epoch_count, 0);
    chk({tag, "_err"}, epoch_err, 0);
  endtask

  initial begin
    tbl[0] = '{0,   0, 0, 1, 1,   0,  4};   // exact answers: converge in 1 epoch
    tbl[1] = '{1, 128, 0, 0, 3, 128, 12};   // y stuck at 0.5: epoch limit
    tbl[2] = '{0,   0, 1, 1, 1,   0,  4};   // sticky fp_valid level
    tbl[3] = '{0,  13, 0, 1, 1,  13,  4};   // error exactly at threshold
    tbl[4] = '{0, -14, 1, 0, 3,  14, 12};   // one above threshold, sticky
    smp[0] = '{0, 0, 0};
    smp[1] = '{0, 256, 256};
    smp[2] = '{256, 0, 256};
    smp[3] = '{256, 256, 0};

    rst = 1'b1; start = 1'b0; stop = 1'b0; y = '0;
    y_fixed = 0; y_val = 0; sticky = 0; bp_never = 0; chk_lat = 0;
    fp_pulses = 0; bp_pulses = 0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // start and stop together in IDLE: nothing happens
    @(negedge clk); start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    chk("ss_busy", busy, 0);
    repeat (4) @(negedge clk);
    chk("ss_fp_pulses", fp_pulses, 0);
    chk("ss_busy2", busy, 0);
    $display("idle start+stop: busy=%0d fp_pulses=%0d", busy, fp_pulses);

    // table-driven training runs
    for (int s = 0; s < 5; s++) begin
      y_fixed = tbl[s].y_fixed; y_val = tbl[s].y_val; sticky = tbl[s].sticky;
      fp_pulses = 0; bp_pulses = 0; chk_lat = 1;
      pulse_start();
      chk("start_busy", busy, 1);          // LOAD cycle
      chk("start_en_fp0", enable_fp, 0);
      @(negedge clk);
      chk("start_en_fp1", enable_fp, 1);   // FP_START cycle
      wait_done(2000);
      chk("run_conv", converged, tbl[s].exp_conv);
      chk("run_timeout", timeout, 0);
      chk("run_busy", busy, 0);
      chk("run_epochs", epoch_count, tbl[s].exp_epochs);
      chk("run_err", epoch_err, tbl[s].exp_err);
      chk("run_idx", sample_idx, 0);
      chk("run_fp_pulses", fp_pulses, tbl[s].exp_pulses);
      chk("run_bp_pulses", bp_pulses, tbl[s].exp_pulses);
      for (int i = 0; i < fp_pulses && i < 16; i++) begin
        chk("log_idx", log_idx[i], i % 4);
        chk("log_x1", log_x1[i], smp[i % 4].x1);
        chk("log_x2", log_x2[i], smp[i % 4].x2);
        chk("log_target", log_tg[i], smp[i % 4].tg);
      end
      $display("scenario %0d: conv=%0d epochs=%0d err=%0d fp=%0d bp=%0d",
               s, converged, epoch_count, epoch_err, fp_pulses, bp_pulses);
    end

    // stop pulsed during BP_WAIT of sample 1
    begin
      bit found = 0;
      y_fixed = 0; y_val = 0; sticky = 0;
      fp_pulses = 0; bp_pulses = 0;
      pulse_start();
      for (int k = 0; k < 500; k++) begin
        @(negedge clk);
        if (enable_bp && sample_idx == 2'd1) begin
          found = 1;
          break;
        end
      end
      chk("stop_bp_seen", found, 1);
      @(negedge clk); stop = 1'b1;
      @(negedge clk); stop = 1'b0;
      wait_done(500);
      chk("stop_conv", converged, 0);
      chk("stop_idx", sample_idx, 1);
      chk("stop_epochs", epoch_count, 0);
      chk("stop_bp_pulses", bp_pulses, 2);
      repeat (20) @(negedge clk);
      chk("stop_fp_pulses", fp_pulses, 2);
      chk("stop_done_held", done, 1);
      $display("stop run: done=%0d idx=%0d fp=%0d bp=%0d",
               done, sample_idx, fp_pulses, bp_pulses);
    end

    // asynchronous reset while in FP_WAIT
    begin
      bit found = 0;
      chk_lat = 0;
      pulse_start();
      for (int k = 0; k < 50; k++) begin
        if (enable_fp) begin
          found = 1;
          break;
        end
        @(negedge clk);
      end
      chk("rst_fp_seen", found, 1);
      repeat (2) @(negedge clk);
      chk("rst_pre_busy", busy, 1);
      rst = 1'b1;
      #1;
      chk_all_zero("rst_async");
      @(negedge clk);
      chk_all_zero("rst_held");
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_idle_busy", busy, 0);
      $display("mid-run reset: busy=%0d done=%0d", busy, done);
    end

`ifdef TRAIN_WATCHDOG_EN
    // BP never completes: timeout exactly 64 cycles after entering BP_WAIT
    begin
      bit found = 0;
      bp_never = 1; chk_lat = 1;
      pulse_start();
      for (int k = 0; k < 50; k++) begin
        if (enable_bp) begin
          found = 1;
          break;
        end
        @(negedge clk);
      end
      chk("wd_bp_seen", found, 1);
      repeat (64) @(negedge clk);
      chk("wd_done_early", done, 0);
      @(negedge clk);
      chk("wd_done", done, 1);
      chk("wd_timeout", timeout, 1);
      chk("wd_conv", converged, 0);
      chk("wd_busy", busy, 0);
      bp_never = 0;
      $display("watchdog: done=%0d timeout=%0d", done, timeout);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
